// File: rtl/serial_sub_ctrl.sv
`default_nettype none
// ============================================================================
// serial_sub_ctrl : bit-serial A-B controller driving one external 1-bit
// full-subtractor cell LSB-first. Optional macro SUB_SIGNED_OVF_EN adds ovf.
// Revision: 1.0
// ============================================================================
module serial_sub_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
`ifdef SUB_SIGNED_OVF_EN
   output logic             ovf,
`endif
   output logic             cell_a,
   output logic             cell_b,
   output logic             cell_bin,
   input  logic             cell_d,
   input  logic             cell_bout
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH-1);

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_res_sh;
   logic [WIDTH-1:0] r_diff;
   logic             r_brw;
   logic             r_borrow;
   logic [CNT_W-1:0] r_cnt;

   logic             w_run;
   logic [WIDTH-1:0] w_res_next;

   assign w_run      = (r_state == S_RUN);
   assign w_res_next = {cell_d, r_res_sh[WIDTH-1:1]};

`ifdef SUB_SIGNED_OVF_EN
   logic r_a_msb;
   logic r_b_msb;
   logic r_ovf;
   logic w_ovf_next;

   // Overflow only possible when operand signs differ; judged on the final difference.
   assign w_ovf_next = (r_a_msb != r_b_msb) && (w_res_next[WIDTH-1] != r_a_msb);
   assign ovf        = r_ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_msb <= 1'b0;
         r_b_msb <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         if (start && (r_state == S_IDLE || r_state == S_DONE)) begin
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
         end
         if (w_run && r_cnt == c_last) begin
            r_ovf <= w_ovf_next;
         end
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_res_sh <= '0;
         r_diff   <= '0;
         r_brw    <= 1'b0;
         r_borrow <= 1'b0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               // DONE accepts start exactly like IDLE for back-to-back operation.
               if (start) begin
                  r_a_sh  <= a;
                  r_b_sh  <= b;
                  r_brw   <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= S_RUN;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_RUN: begin
               r_res_sh <= w_res_next;
               r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
               r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
               r_brw    <= cell_bout;
               r_cnt    <= r_cnt + 1'b1;
               if (r_cnt == c_last) begin
                  r_diff   <= w_res_next;
                  r_borrow <= cell_bout;
                  r_state  <= S_DONE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy       = w_run;
   assign done       = (r_state == S_DONE);
   assign diff       = r_diff;
   assign borrow_out = r_borrow;
   assign cell_a     = w_run & r_a_sh[0];
   assign cell_b     = w_run & r_b_sh[0];
   assign cell_bin   = w_run & r_brw;

endmodule
`default_nettype wire
